// File: rtl/fft_pkg.sv
// Shared constants, state encoding and sample-to-bank mapping
// for the 32-point in-place radix-2 FFT stage sequencer.
package fft_pkg;

  localparam int NUMSAMPLES = 32;
  localparam int NUMSTAGES  = 5;
  localparam int ADDRSIZE   = 3;
  localparam int NUMWORDS   = 8;
  localparam int LAT        = 2;

  localparam logic [2:0] LAST_NONE = 3'd7;
  localparam logic [3:0] RUN_LAST  = 4'(NUMWORDS + LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef logic [ADDRSIZE-1:0] addr_t;

  function automatic logic [1:0] bank_of(input logic [4:0] n);
    return {n[4] ^ n[2] ^ n[0], ^n};
  endfunction

  function automatic addr_t addr_of(input logic [4:0] n);
    return n[4:2];
  endfunction

  // Open a zero bit at position pos, shifting higher bits up.
  function automatic logic [4:0] ins_zero(
    input logic [4:0] v,
    input logic [2:0] pos
  );
    logic [4:0] lo_mask;
    lo_mask = (5'd1 << pos) - 5'd1;
    return ((v & ~lo_mask) << 1) | (v & lo_mask);
  endfunction

endpackage

// File: rtl/fft_stage_control_addr_gen.sv
// Combinational operand generator: stage and cycle in,
// per-bank read addresses and operand steering out.
module fft_addr_gen
  import fft_pkg::*;
(
  input  logic [2:0]               stage,
  input  logic [2:0]               cnt,
  output logic [3:0][ADDRSIZE-1:0] rd_addr,
  output logic [1:0]               m1_s,
  output logic                     m3_s
);

  logic [2:0] j;
  logic [2:0] lo;
  logic [2:0] hi;
  logic [4:0] x;
  logic [4:0] sb;
  logic [4:0] jb;
  logic [3:0][4:0] op;

  // Build the four butterfly operands and route each to its bank.
  always_comb begin
    j  = (stage == 3'd1 || stage == 3'd3) ? 3'd0 : 3'd1;
    lo = (stage < j) ? stage : j;
    hi = (stage < j) ? j : stage;
    x  = ins_zero(ins_zero({2'b00, cnt}, lo), hi);
    sb = 5'd1 << stage;
    jb = 5'd1 << j;
    op[0] = x;
    op[1] = x ^ sb;
    op[2] = x ^ jb;
    op[3] = x ^ sb ^ jb;
    rd_addr = '0;
    for (int k = 0; k < 4; k++) begin
      rd_addr[bank_of(op[k])] = addr_of(op[k]);
    end
    m1_s = bank_of(x);
    m3_s = ~stage[0];
  end

endmodule

// File: rtl/fft_stage_control.sv
// Per-stage sequencer: stage FSM, read counter, and the
// LAT-deep delay line producing write addresses.
module fft_stage_control
  import fft_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en_stage,
  input  logic [2:0]          stage_num,
  output logic                m0_s,
  output logic [1:0]          m1_s,
  output logic                m2_s,
  output logic                m3_s,
  output logic [ADDRSIZE-1:0] rd_addr0,
  output logic [ADDRSIZE-1:0] rd_addr1,
  output logic [ADDRSIZE-1:0] rd_addr2,
  output logic [ADDRSIZE-1:0] rd_addr3,
  output logic [ADDRSIZE-1:0] wr_addr0,
  output logic [ADDRSIZE-1:0] wr_addr1,
  output logic [ADDRSIZE-1:0] wr_addr2,
  output logic [ADDRSIZE-1:0] wr_addr3,
  output logic                stage_done
);

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] stage_q, stage_d;
  logic [2:0] last_q, last_d;
  logic       done_q, done_d;

  logic [LAT-1:0][3:0][ADDRSIZE-1:0] dly_a_q, dly_a_d;
  logic [LAT-1:0]                    dly_m_q, dly_m_d;

  logic [3:0][ADDRSIZE-1:0] rd_addr;
  logic [1:0] gen_m1;
  logic       gen_m3;
  logic [2:0] rd_cnt;
  logic       rd_act;
  logic       start;

  // Drain cycles keep the last read address so idle output holds.
  assign rd_act = (state_q == ST_RUN) && (cnt_q < 4'd8);
  assign rd_cnt = (cnt_q < 4'd8) ? cnt_q[2:0] : 3'd7;
  assign start  = (stage_num != last_q) &&
                  (stage_num < 3'(NUMSTAGES));

  fft_addr_gen u_addr_gen (
    .stage   (stage_q),
    .cnt     (rd_cnt),
    .rd_addr (rd_addr),
    .m1_s    (gen_m1),
    .m3_s    (gen_m3)
  );

  // Next-state logic: abort on en_stage low, else idle/run/done.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    last_d  = last_q;
    done_d  = done_q;
    if (!en_stage) begin
      state_d = ST_IDLE;
      last_d  = LAST_NONE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_RUN;
            cnt_d   = 4'd0;
            stage_d = stage_num;
          end
        end
        ST_RUN: begin
          if (cnt_q == RUN_LAST) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        ST_DONE: begin
          done_d  = ~done_q;
          last_d  = stage_q;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Write side trails the read side by exactly LAT cycles.
  always_comb begin
    dly_a_d    = dly_a_q;
    dly_m_d    = dly_m_q;
    dly_a_d[0] = rd_addr;
    dly_m_d[0] = m3_s;
    for (int i = 1; i < LAT; i++) begin
      dly_a_d[i] = dly_a_q[i-1];
      dly_m_d[i] = dly_m_q[i-1];
    end
  end

  // State and delay-line registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      stage_q <= '0;
      last_q  <= LAST_NONE;
      done_q  <= 1'b0;
      dly_a_q <= '0;
      dly_m_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      last_q  <= last_d;
      done_q  <= done_d;
      dly_a_q <= dly_a_d;
      dly_m_q <= dly_m_d;
    end
  end

  assign m0_s       = (state_q != ST_RUN);
  assign m1_s       = rd_act ? gen_m1 : 2'd0;
  assign m3_s       = rd_act & gen_m3;
  assign m2_s       = dly_m_q[LAT-1];
  assign rd_addr0   = rd_addr[0];
  assign rd_addr1   = rd_addr[1];
  assign rd_addr2   = rd_addr[2];
  assign rd_addr3   = rd_addr[3];
  assign wr_addr0   = dly_a_q[LAT-1][0];
  assign wr_addr1   = dly_a_q[LAT-1][1];
  assign wr_addr2   = dly_a_q[LAT-1][2];
  assign wr_addr3   = dly_a_q[LAT-1][3];
  assign stage_done = done_q;

endmodule

// File: tb/tb_fft_stage_control.sv
// Directed bench for fft_stage_control: reset, per-stage
// addressing, write delay, stage sequencing and abort.
module tb_fft_stage_control;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_stage;
  logic [2:0] stage_num;
  logic       m0_s, m2_s, m3_s, stage_done;
  logic [1:0] m1_s;
  logic [2:0] rd_addr0, rd_addr1, rd_addr2, rd_addr3;
  logic [2:0] wr_addr0, wr_addr1, wr_addr2, wr_addr3;

  logic [2:0] rd [4];
  logic [2:0] wr [4];

  int n_chk = 0;
  int n_err = 0;

  int exp_a [4];
  int exp_m1;

  always #5 clk = ~clk;

  assign rd[0] = rd_addr0;
  assign rd[1] = rd_addr1;
  assign rd[2] = rd_addr2;
  assign rd[3] = rd_addr3;
  assign wr[0] = wr_addr0;
  assign wr[1] = wr_addr1;
  assign wr[2] = wr_addr2;
  assign wr[3] = wr_addr3;

  fft_stage_control dut (
    .clk        (clk),
    .rst        (rst),
    .en_stage   (en_stage),
    .stage_num  (stage_num),
    .m0_s       (m0_s),
    .m1_s       (m1_s),
    .m2_s       (m2_s),
    .m3_s       (m3_s),
    .rd_addr0   (rd_addr0),
    .rd_addr1   (rd_addr1),
    .rd_addr2   (rd_addr2),
    .rd_addr3   (rd_addr3),
    .wr_addr0   (wr_addr0),
    .wr_addr1   (wr_addr1),
    .wr_addr2   (wr_addr2),
    .wr_addr3   (wr_addr3),
    .stage_done (stage_done)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int bk(input int n);
    logic [4:0] v;
    v = 5'(n);
    return {30'd0, v[4] ^ v[2] ^ v[0], ^v};
  endfunction

  // Reference: c-th index (ascending) with bits s and j clear.
  task automatic model(input int s, input int c);
    int j, k, x, sb, jb;
    int ops [4];
    j = (s == 1 || s == 3) ? 0 : 1;
    k = 0;
    x = 0;
    for (int n = 0; n < 32; n++) begin
      if (((n >> s) & 1) == 0 && ((n >> j) & 1) == 0) begin
        if (k == c) x = n;
        k++;
      end
    end
    sb = 1 << s;
    jb = 1 << j;
    ops[0] = x;
    ops[1] = x ^ sb;
    ops[2] = x ^ jb;
    ops[3] = x ^ sb ^ jb;
    for (int i = 0; i < 4; i++) exp_a[i] = -1;
    for (int i = 0; i < 4; i++) exp_a[bk(ops[i])] = ops[i] >> 2;
    exp_m1 = bk(x);
  endtask

  // Write side must equal read side from two cycles earlier.
  int       hv = 0;
  logic [2:0] h1 [4];
  logic [2:0] h2 [4];
  logic       hm1, hm2;

  always @(negedge clk) begin
    if (rst) begin
      hv = 0;
    end else begin
      if (hv >= 2) begin
        for (int b = 0; b < 4; b++) chk($sformatf("wr%0d", b), wr[b], h2[b]);
        chk("m2_s", m2_s, hm2);
      end
      for (int b = 0; b < 4; b++) begin
        h2[b] = h1[b];
        h1[b] = rd[b];
      end
      hm2 = hm1;
      hm1 = m3_s;
      hv++;
    end
  end

  task automatic run_stage(input int s);
    int seen [32];
    int prev, done_at, ones;
    for (int n = 0; n < 32; n++) seen[n] = 0;
    prev      = stage_done;
    done_at   = 0;
    stage_num = 3'(s);
    en_stage  = 1'b1;
    for (int t = 1; t <= 20 && done_at == 0; t++) begin
      tick();
      if (t <= 8) begin
        model(s, t - 1);
        for (int b = 0; b < 4; b++)
          chk($sformatf("s%0d c%0d rd%0d", s, t - 1, b), rd[b], exp_a[b]);
        chk($sformatf("s%0d c%0d m1", s, t - 1), m1_s, exp_m1);
        chk($sformatf("s%0d m3", s), m3_s, (s % 2 == 0) ? 1 : 0);
        chk($sformatf("s%0d m0", s), m0_s, 0);
        for (int b = 0; b < 4; b++)
          for (int n = 0; n < 32; n++)
            if ((n >> 2) == rd[b] && bk(n) == b) seen[n]++;
      end
      if (stage_done != prev) done_at = t;
    end
    ones = 0;
    for (int n = 0; n < 32; n++) if (seen[n] == 1) ones++;
    chk($sformatf("s%0d cover", s), ones, 32);
    chk($sformatf("s%0d done_at", s), done_at, 12);
    chk($sformatf("s%0d done_val", s), stage_done, (prev == 0) ? 1 : 0);
    chk($sformatf("s%0d idle_m0", s), m0_s, 1);
    model(s, 7);
    for (int b = 0; b < 4; b++)
      chk($sformatf("s%0d hold%0d", s, b), rd[b], exp_a[b]);
  endtask

  task automatic idle_for(input string tag, input int cyc);
    int busy;
    busy = 0;
    for (int t = 0; t < cyc; t++) begin
      tick();
      if (m0_s == 1'b0 || m3_s == 1'b1) busy++;
    end
    chk(tag, busy, 0);
  endtask

  initial begin
    rst       = 1'b1;
    en_stage  = 1'b0;
    stage_num = 3'd0;
    repeat (2) tick();
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("rst rd%0d", b), rd[b], 0);
      chk($sformatf("rst wr%0d", b), wr[b], 0);
    end
    chk("rst done", stage_done, 0);
    chk("rst m0", m0_s, 1);
    chk("rst m1", m1_s, 0);
    chk("rst m3", m3_s, 0);
    rst = 1'b0;
    idle_for("en0 idle", 6);
    chk("en0 done", stage_done, 0);

    for (int s = 0; s < 5; s++) begin
      run_stage(s);
      chk($sformatf("seq s%0d", s), stage_done, (s % 2 == 0) ? 1 : 0);
    end

    idle_for("no restart", 15);
    stage_num = 3'd5;
    idle_for("stage5", 15);
    stage_num = 3'd7;
    idle_for("stage7", 15);
    chk("hold done", stage_done, 1);

    stage_num = 3'd2;
    en_stage  = 1'b1;
    repeat (4) tick();
    chk("abort run", m0_s, 0);
    en_stage = 1'b0;
    tick();
    chk("abort m0", m0_s, 1);
    chk("abort m3", m3_s, 0);
    idle_for("abort idle", 15);
    chk("abort done", stage_done, 1);
    run_stage(2);
    chk("restart done", stage_done, 0);

    stage_num = 3'd1;
    en_stage  = 1'b1;
    repeat (4) tick();
    rst      = 1'b1;
    en_stage = 1'b0;
    #1;
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("arst rd%0d", b), rd[b], 0);
      chk($sformatf("arst wr%0d", b), wr[b], 0);
    end
    chk("arst m0", m0_s, 1);
    chk("arst m1", m1_s, 0);
    chk("arst m2", m2_s, 0);
    chk("arst m3", m3_s, 0);
    chk("arst done", stage_done, 0);
    tick();
    rst = 1'b0;
    idle_for("post rst", 4);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
